// File: rtl/combo_led_sequencer.sv
// -----------------------------------------------------------------------------
// combo_led_sequencer
//
// Purpose:
//   Tracks the player's combo (consecutive hits, cleared on a miss) and drives
//   the 16-LED combo bar directly. When the combo reaches 15 it plays a timed
//   celebration: a left-to-right fill sweep, then FLASH_COUNT off/on flash
//   pairs. After that the combo returns to 0 and counting rearms.
//
// Parameters:
//   TICK_DIV    - clock cycles per animation step (>= 2)
//   FLASH_COUNT - number of off/on flash pairs after the sweep (>= 1)
//
// Ports:
//   clk       in   system clock, rising-edge
//   rst       in   asynchronous, active-high reset
//   hit       in   single-cycle pulse, note judged hit
//   miss      in   single-cycle pulse, note judged miss (wins over hit)
//   combo     out  [3:0]  current combo count 0..15
//   led       out  [15:0] LED bar, bit 0 = leftmost / first lit
//   busy      out  high while the celebration animation runs
//   max_pulse out  one-cycle pulse on the edge the combo reaches 15
// -----------------------------------------------------------------------------
module combo_led_sequencer #(
    parameter int TICK_DIV    = 1000000,
    parameter int FLASH_COUNT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hit,
    input  logic        miss,
    output logic [3:0]  combo,
    output logic [15:0] led,
    output logic        busy,
    output logic        max_pulse
);

    localparam int PRW = $clog2(TICK_DIV);
    localparam int PHW = $clog2(2 * FLASH_COUNT);
    localparam logic [PRW-1:0] TICK_LAST  = PRW'(TICK_DIV - 1);
    localparam logic [PHW-1:0] PHASE_LAST = PHW'(2 * FLASH_COUNT - 1);

    typedef enum logic [1:0] {
        ST_COUNT,
        ST_SWEEP,
        ST_FLASH
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      combo_q, combo_d;
    logic [15:0]     led_q, led_d;
    logic            busy_q, busy_d;
    logic            max_pulse_q, max_pulse_d;
    logic [3:0]      step_q, step_d;
    logic [PHW-1:0]  phase_q, phase_d;
    logic [PRW-1:0]  presc_q, presc_d;

    // Thermometer code for the combo value one hit ahead, so the bar can be
    // updated on the same edge as the counter.
    logic [3:0]  combo_inc;
    logic [15:0] thermo_inc;

    assign combo_inc = combo_q + 4'd1;

    for (genvar gi = 0; gi < 16; gi++) begin : g_thermo
        assign thermo_inc[gi] = (combo_inc > 4'(gi));
    end

    logic       tick_wrap;
    logic [3:0] step_inc;
    logic [PHW-1:0] phase_inc;

    assign tick_wrap = (presc_q == TICK_LAST);
    assign step_inc  = step_q + 4'd1;
    assign phase_inc = phase_q + PHW'(1);

    always_comb begin
        state_d     = state_q;
        combo_d     = combo_q;
        led_d       = led_q;
        busy_d      = busy_q;
        max_pulse_d = 1'b0;
        step_d      = step_q;
        phase_d     = phase_q;
        presc_d     = presc_q;

        case (state_q)
            ST_COUNT: begin
                presc_d = '0;
                if (miss) begin
                    combo_d = 4'd0;
                    led_d   = 16'h0000;
                end else if (hit) begin
                    if (combo_q == 4'd14) begin
                        // Saturation: start the celebration on this edge.
                        combo_d     = 4'd15;
                        max_pulse_d = 1'b1;
                        busy_d      = 1'b1;
                        led_d       = 16'h0001;
                        step_d      = 4'd0;
                        presc_d     = '0;
                        state_d     = ST_SWEEP;
                    end else if (combo_q < 4'd14) begin
                        combo_d = combo_inc;
                        led_d   = thermo_inc;
                    end
                end
            end

            ST_SWEEP, ST_FLASH: begin
                if (miss) begin
                    // Abort takes priority over any tick wrap this cycle.
                    state_d = ST_COUNT;
                    combo_d = 4'd0;
                    led_d   = 16'h0000;
                    busy_d  = 1'b0;
                    step_d  = 4'd0;
                    phase_d = '0;
                    presc_d = '0;
                end else begin
                    presc_d = tick_wrap ? '0 : presc_q + PRW'(1);
                    if (tick_wrap) begin
                        if (state_q == ST_SWEEP) begin
                            if (step_q == 4'd15) begin
                                state_d = ST_FLASH;
                                phase_d = '0;
                                led_d   = 16'h0000;
                            end else begin
                                step_d = step_inc;
                                // Fill pattern: step+1 low bits set.
                                led_d  = ~(16'hFFFE << step_inc);
                            end
                        end else begin
                            if (phase_q == PHASE_LAST) begin
                                state_d = ST_COUNT;
                                combo_d = 4'd0;
                                led_d   = 16'h0000;
                                busy_d  = 1'b0;
                                phase_d = '0;
                                step_d  = 4'd0;
                                presc_d = '0;
                            end else begin
                                phase_d = phase_inc;
                                // Odd phases are the "on" half of a flash pair.
                                led_d   = phase_inc[0] ? 16'hFFFF : 16'h0000;
                            end
                        end
                    end
                end
            end

            default: begin
                state_d = ST_COUNT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_COUNT;
            combo_q     <= 4'd0;
            led_q       <= 16'h0000;
            busy_q      <= 1'b0;
            max_pulse_q <= 1'b0;
            step_q      <= 4'd0;
            phase_q     <= '0;
            presc_q     <= '0;
        end else begin
            state_q     <= state_d;
            combo_q     <= combo_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
            max_pulse_q <= max_pulse_d;
            step_q      <= step_d;
            phase_q     <= phase_d;
            presc_q     <= presc_d;
        end
    end

    assign combo     = combo_q;
    assign led       = led_q;
    assign busy      = busy_q;
    assign max_pulse = max_pulse_q;

endmodule

// File: tb/tb_combo_led_sequencer.sv
// -----------------------------------------------------------------------------
// tb_combo_led_sequencer
//
// Directed bench for combo_led_sequencer with TICK_DIV=4, FLASH_COUNT=3
// (88-cycle celebration). Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point, i.e. after the edge has settled.
// -----------------------------------------------------------------------------
module tb_combo_led_sequencer;

    localparam int TICK_DIV    = 4;
    localparam int FLASH_COUNT = 3;
    localparam int ANIM_LEN    = (16 + 2 * FLASH_COUNT) * TICK_DIV;  // 88
    localparam int SWEEP_LEN   = 16 * TICK_DIV;                      // 64

    logic        clk;
    logic        rst;
    logic        hit;
    logic        miss;
    logic [3:0]  combo;
    logic [15:0] led;
    logic        busy;
    logic        max_pulse;

    int n_vec;
    int n_err;

    combo_led_sequencer #(
        .TICK_DIV   (TICK_DIV),
        .FLASH_COUNT(FLASH_COUNT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .hit      (hit),
        .miss     (miss),
        .combo    (combo),
        .led      (led),
        .busy     (busy),
        .max_pulse(max_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle with the given inputs; returns 1 unit after the edge.
    task automatic cyc(input logic h, input logic m);
        hit  = h;
        miss = m;
        @(posedge clk);
        #1;
        hit  = 1'b0;
        miss = 1'b0;
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0);
    endtask

    task automatic chk_idle(input string tag, input int exp_combo, input int exp_led);
        chk({tag, " combo"}, 32'(combo), 32'(exp_combo));
        chk({tag, " led"},   32'(led),   32'(exp_led));
        chk({tag, " busy"},  32'(busy),  32'd0);
    endtask

    task automatic async_reset_check(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, " combo"}, 32'(combo),     32'd0);
        chk({tag, " led"},   32'(led),       32'd0);
        chk({tag, " busy"},  32'(busy),      32'd0);
        chk({tag, " maxp"},  32'(max_pulse), 32'd0);
        #1;
        rst = 1'b0;
    endtask

    // From combo 0: 14 hits, then the saturating hit with its checks.
    task automatic start_anim(input string tag);
        hits(14);
        chk({tag, " combo14"}, 32'(combo), 32'd14);
        chk({tag, " led14"},   32'(led),   32'h3FFF);
        chk({tag, " maxp14"},  32'(max_pulse), 32'd0);
        cyc(1'b1, 1'b0);
        chk({tag, " maxp"},  32'(max_pulse), 32'd1);
        chk({tag, " busy"},  32'(busy),      32'd1);
        chk({tag, " led0"},  32'(led),       32'h0001);
        chk({tag, " combo"}, 32'(combo),     32'd15);
    endtask

    // Run cycles 1..stop_at after the max_pulse edge, checking each cycle
    // against the expected timeline.
    task automatic run_anim(input string tag, input logic h, input int stop_at);
        int s;
        int p;
        int exp_led;
        for (int t = 1; t <= stop_at; t++) begin
            cyc(h, 1'b0);
            if (t < SWEEP_LEN) begin
                s = t / TICK_DIV;
                exp_led = (1 << (s + 1)) - 1;
            end else if (t < ANIM_LEN) begin
                p = (t - SWEEP_LEN) / TICK_DIV;
                exp_led = (p % 2 == 1) ? 32'hFFFF : 0;
            end else begin
                exp_led = 0;
            end
            chk($sformatf("%s t%0d led", tag, t),   32'(led),       32'(exp_led));
            chk($sformatf("%s t%0d busy", tag, t),  32'(busy),      (t < ANIM_LEN) ? 32'd1 : 32'd0);
            chk($sformatf("%s t%0d combo", tag, t), 32'(combo),     (t < ANIM_LEN) ? 32'd15 : 32'd0);
            chk($sformatf("%s t%0d maxp", tag, t),  32'(max_pulse), 32'd0);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        hit   = 1'b0;
        miss  = 1'b0;

        // Reset state
        #12;
        chk("rst combo", 32'(combo),     32'd0);
        chk("rst led",   32'(led),       32'd0);
        chk("rst busy",  32'(busy),      32'd0);
        chk("rst maxp",  32'(max_pulse), 32'd0);
        rst = 1'b0;

        // Counting, then asynchronous reset mid-count
        hits(5);
        chk_idle("count5", 5, 16'h001F);
        async_reset_check("arst_count");
        hits(3);
        chk_idle("count3", 3, 16'h0007);

        // Miss after 7 hits, and hit/miss collision
        hits(4);
        chk_idle("count7", 7, 16'h007F);
        cyc(1'b0, 1'b1);
        chk_idle("miss7", 0, 16'h0000);
        hits(2);
        chk_idle("count2", 2, 16'h0003);
        cyc(1'b1, 1'b1);
        chk_idle("hitmiss", 0, 16'h0000);

        // Full animation, plus named milestones
        start_anim("anim1");
        run_anim("anim1", 1'b0, ANIM_LEN);
        chk_idle("anim1_end", 0, 16'h0000);

        // Hits every cycle during the animation are ignored
        start_anim("anim2");
        run_anim("anim2", 1'b1, ANIM_LEN);
        chk_idle("anim2_end", 0, 16'h0000);
        cyc(1'b1, 1'b0);
        chk_idle("after_anim", 1, 16'h0001);
        cyc(1'b0, 1'b1);
        chk_idle("clr", 0, 16'h0000);

        // Abort in flash phase 3 (edges 76..79)
        start_anim("anim3");
        run_anim("anim3", 1'b0, 77);
        chk("abort_pre led", 32'(led), 32'hFFFF);
        cyc(1'b0, 1'b1);
        chk_idle("abort", 0, 16'h0000);
        cyc(1'b1, 1'b0);
        chk_idle("abort_hit", 1, 16'h0001);
        cyc(1'b0, 1'b1);

        // Asynchronous reset at step 8 of the sweep (edges 32..35)
        start_anim("anim4");
        run_anim("anim4", 1'b0, 33);
        chk("step8 led", 32'(led), 32'h01FF);
        async_reset_check("arst_sweep");
        start_anim("anim5");
        run_anim("anim5", 1'b0, ANIM_LEN);
        chk_idle("anim5_end", 0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net: the bench must end on its own.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/combo_led_sequencer.md
Name: combo_led_sequencer

Overview:
- Owns the combo count for the game: counts consecutive hits and resets the count on a miss.
- Drives the 16-LED combo bar directly.
- When the combo saturates at 15, runs a timed celebration animation (a fill sweep followed by flashes) on the bar, then rearms.
- Sits between the hit-judgement logic and the board LEDs, and replaces the purely combinational combo-to-LED decode.

Parameters:
TICK_DIV, 1000000, clock cycles per animation step (must be ≥ 2)
FLASH_COUNT, 3, number of off/on flash pairs after the sweep (must be ≥ 1)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
hit  input  1  single-cycle pulse: note judged hit
miss  input  1  single-cycle pulse: note judged miss
combo  output  4  current combo count, 0..15
led  output  16  LED bar drive, bit 0 = leftmost/first lit
busy  output  1  high while the celebration animation runs
max_pulse  output  1  one-cycle pulse when the combo reaches 15

Behaviour:
- Interface fixed: one clock (clk); rst is asynchronous and active-high. All outputs are registered.
- Reset values: state=COUNT, combo=0, led=16'h0000, busy=0, max_pulse=0, step and prescaler cleared. Reset asserted mid-animation aborts it immediately.
- COUNT state:
  - led = thermometer(combo): low combo bits set, bit 15 always 0 (e.g. combo=5 gives 16'h001F).
  - hit with combo<14: combo+1 on the next edge; led updates on the same edge (1-cycle latency).
  - hit with combo==14: combo=15, max_pulse=1 for exactly one cycle, busy=1, led=16'h0001, step=0, prescaler=0, enter SWEEP, all on that one edge.
  - miss: combo=0, led=16'h0000 on the next edge.
  - hit and miss in the same cycle: miss wins.
- SWEEP state:
  - Prescaler counts 0..TICK_DIV-1. On wrap, step increments and led = (2^(step+1))-1, so the bar fills one LED per tick from 16'h0001 to 16'hFFFF.
  - Each pattern is held exactly TICK_DIV cycles.
  - When the wrap occurs at step 15 (16'hFFFF has been held TICK_DIV cycles): enter FLASH with phase=0 and led=16'h0000.
- FLASH state:
  - phase counts 0..2*FLASH_COUNT-1, advancing on each prescaler wrap.
  - Even phase: led=16'h0000. Odd phase: led=16'hFFFF.
  - On the wrap after the last phase: combo=0, led=16'h0000, busy=0, return to COUNT.
- Total animation length: (16+2*FLASH_COUNT)*TICK_DIV cycles from the max_pulse edge to the busy fall.
- combo holds 15 throughout SWEEP and FLASH.
- hit is ignored during SWEEP and FLASH.
- miss during SWEEP or FLASH aborts on the next edge: combo=0, led=0, busy=0, state=COUNT. Miss wins over a same-cycle tick wrap.
- max_pulse is never asserted outside the COUNT→SWEEP transition.
- No wrap-around of combo is possible: 15 is reached only via the transition into SWEEP.
- Prescaler runs only in SWEEP and FLASH and is cleared on entry to SWEEP. Phase boundaries are therefore deterministic relative to max_pulse.

Test Plan:
- Reset mid-count: 5 hits then assert rst → combo=0, led=16'h0000, busy=0 with no clk edge needed. After 3 hits: combo=3, led=16'h0007.
- Miss and hit/miss collision: 7 hits then a miss → combo=0, led=0 one cycle after the miss. 2 hits then hit and miss together → combo=0.
- Full animation (TICK_DIV=4, FLASH_COUNT=3): 15 hits →
  - the 15th hit produces max_pulse for 1 cycle, busy=1, led=16'h0001;
  - led=16'h0003 four cycles later and 16'hFFFF at cycle 60;
  - flashes 0000/FFFF ×3 at 4 cycles each;
  - busy falls at cycle 88 with combo=0, led=0.
- Hits ignored during animation: pulse hit every cycle during SWEEP → combo stays 15 and animation timing is unchanged. First hit after busy falls → combo=1, led=16'h0001.
- Abort mid-flash: miss in FLASH phase 3 → next edge combo=0, led=0, busy=0. A following hit → combo=1.
- Async reset mid-sweep: rst pulse between clk edges at step 8 → outputs return to reset values immediately. A subsequent 15 hits replays the full 88-cycle animation.
